dma_copier: RTL and testbench

- Bus initiator (DMA engine) for the SoC's byte-wide valid/write/ready memory bus; drives the same handshake that on-chip memories answer.
- Performs block fill (constant byte) or block copy (read then write) over a 64 KiB address space.
- Sits between a CPU-visible control register block and a memory responder such as the 64K BRAM.
- One transfer active at a time.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_copier_wdog.sv | 32 +++
 rtl/dma_copier.sv | 159 +++++++++++++++
 tb/tb_dma_copier.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_copier block-fill/copy engine.
// Holds the FSM state type, mode encodings and the default access timeout.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RGAP,
    WR,
    WGAP,
    DONE
  } state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/dma_copier_wdog.sv
// Per-access watchdog: counts cycles while a bus request is outstanding.
// Ports: clk, reset, en (request pending), expired (TIMEOUT-th cycle reached).
module dma_wdog
  import dma_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Every request is preceded by a cycle with en low, so the
  // counter is always fresh when a new access starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/dma_copier.sv
// DMA initiator: block fill or block copy over a 64 KiB byte bus.
// Ports: start/mode/src/dst/len/fill control, busy/done/err/count status,
// mem_* valid/write/ready bus. Optional per-access abort: DMA_TIMEOUT_EN.
module dma_copier
  import dma_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [15:0]      src,
  input  logic [15:0]      dst,
  input  logic [CNT_W-1:0] len,
  input  logic [7:0]       fill,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic             mem_valid,
  output logic             mem_write,
  input  logic             mem_ready
);

  state_t           state;
  logic [15:0]      src_ptr;
  logic [15:0]      dst_ptr;
  logic [CNT_W-1:0] rem;
  logic [7:0]       data_q;
  logic             mode_q;
  logic             tmo;

`ifdef DMA_TIMEOUT_EN
  dma_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .en     (mem_valid),
    .expired(tmo)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      rem       <= '0;
      data_q    <= '0;
      mode_q    <= MODE_FILL;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err   <= 1'b0;
            count <= '0;
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              src_ptr   <= src;
              dst_ptr   <= dst;
              rem       <= len;
              mode_q    <= mode;
              data_q    <= fill;
              busy      <= 1'b1;
              mem_valid <= 1'b1;
              if (mode == MODE_COPY) begin
                state     <= RD;
                mem_write <= 1'b0;
                mem_addr  <= src;
              end else begin
                state     <= WR;
                mem_write <= 1'b1;
                mem_addr  <= dst;
                mem_wdata <= fill;
              end
            end
          end
        end
        RD: begin
          if (mem_ready) begin
            data_q    <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= RGAP;
          end else if (tmo) begin
            mem_valid <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= DONE;
          end
        end
        RGAP: begin
          mem_valid <= 1'b1;
          mem_write <= 1'b1;
          mem_addr  <= dst_ptr;
          mem_wdata <= data_q;
          state     <= WR;
        end
        WR: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WGAP;
          end else if (tmo) begin
            mem_valid <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            state     <= DONE;
          end
        end
        WGAP: begin
          src_ptr <= src_ptr + 16'd1;
          dst_ptr <= dst_ptr + 16'd1;
          count   <= count + CNT_W'(1);
          rem     <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (mode_q == MODE_COPY) begin
            mem_valid <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= src_ptr + 16'd1;
            state     <= RD;
          end else begin
            mem_valid <= 1'b1;
            mem_write <= 1'b1;
            mem_addr  <= dst_ptr + 16'd1;
            mem_wdata <= data_q;
            state     <= WR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copier.sv
// Self-checking bench for dma_copier against a byte-array reference model.
// Byte-wide responder with optional random wait states; optional timeout test.
module tb_dma_copier;
  import dma_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mode;
  logic [15:0]      src;
  logic [15:0]      dst;
  logic [CNT_W-1:0] len;
  logic [7:0]       fill;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] count;
  logic [15:0]      mem_addr;
  logic [7:0]       mem_wdata;
  logic [7:0]       mem_rdata;
  logic             mem_valid;
  logic             mem_write;
  logic             mem_ready;

  always #5 clk = ~clk;

  dma_copier #(
    .TIMEOUT(8),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill     (fill),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count    (count),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_ready(mem_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];

  bit stall_en  = 0;
  bit never_rdy = 0;
  int wr_cnt    = 0;
  int srun      = 0;

  // Byte memory responder: ready one cycle after a request, or later
  // when random stalls are on (at most 3 in a row).
  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      srun = 0;
    end else if (mem_valid && !mem_ready && !never_rdy) begin
      if (stall_en && srun < 3 && $urandom_range(0, 3) == 0) begin
        srun++;
        mem_ready <= 1'b0;
      end else begin
        srun = 0;
        mem_ready <= 1'b1;
        if (mem_write) begin
          mem[mem_addr] = mem_wdata;
          wr_cnt++;
        end else begin
          mem_rdata <= mem[mem_addr];
        end
      end
    end else begin
      mem_ready <= 1'b0;
    end
  end

  int          cyc       = 0;
  int          first_v   = -1;
  int          done_cyc  = -1;
  int          done_cnt  = 0;
  int          viol      = 0;
  bit          busy_seen = 0;
  bit          vld_seen  = 0;
  logic        err_done  = 1'b0;
  logic        pv        = 1'b0;
  logic        pr        = 1'b0;
  logic        pw        = 1'b0;
  logic [15:0] pa        = '0;
  logic [7:0]  pwd       = '0;

  // Bus monitor: request must hold until accepted, then drop.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      if (mem_valid) begin
        vld_seen = 1;
        if (first_v < 0) first_v = cyc;
      end
      if (busy) busy_seen = 1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        err_done = err;
      end
      if (pv && !pr && (!mem_valid || mem_addr != pa ||
          mem_write != pw || (pw && mem_wdata != pwd)))
        viol++;
      if (pv && pr && mem_valid) viol++;
    end
    pv  = mem_valid && !reset;
    pr  = mem_ready;
    pw  = mem_write;
    pa  = mem_addr;
    pwd = mem_wdata;
  end

  task automatic clear_mon();
    first_v   = -1;
    done_cyc  = -1;
    done_cnt  = 0;
    viol      = 0;
    busy_seen = 0;
    vld_seen  = 0;
    wr_cnt    = 0;
  endtask

  // Reference: bytes are moved one at a time in ascending order.
  task automatic ref_xfer(bit m, logic [15:0] s, logic [15:0] d,
                          int n, logic [7:0] f);
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa;
      logic [15:0] da;
      sa = s + 16'(i);
      da = d + 16'(i);
      ref_mem[da] = m ? ref_mem[sa] : f;
    end
  endtask

  task automatic mem_check(string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 65536; a++)
      if (mem[a] !== ref_mem[a]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic wait_done(int limit);
    int t;
    t = 0;
    while (done_cnt == 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == 0)
      $display("FAIL done_timeout: got none expected done");
  endtask

  task automatic kick(bit m, logic [15:0] s, logic [15:0] d,
                      int n, logic [7:0] f);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    src   = s;
    dst   = d;
    len   = CNT_W'(n);
    fill  = f;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(string tag, bit m, logic [15:0] s,
                          logic [15:0] d, int n, logic [7:0] f,
                          bit poke);
    clear_mon();
    kick(m, s, d, n, f);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      mode  = ~m;
      src   = 16'($urandom);
      dst   = 16'($urandom);
      len   = CNT_W'($urandom_range(1, 9));
      fill  = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(20000);
    repeat (2) @(negedge clk);
    ref_xfer(m, s, d, n, f);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_count"}, count, n);
    chk({tag, "_err"}, err_done, 0);
    chk({tag, "_proto"}, viol, 0);
    chk({tag, "_busy"}, busy, 0);
    if (!stall_en)
      chk({tag, "_cycles"}, done_cyc - first_v, m ? 6 * n : 3 * n);
    mem_check({tag, "_mem"});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    src   = '0;
    dst   = '0;
    len   = '0;
    fill  = '0;
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 8'($urandom);
      ref_mem[a] = mem[a];
    end
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {busy, done, err, mem_valid, mem_write, count, mem_addr},
        0);
    chk("reset_wdata", mem_wdata, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer("fill", MODE_FILL, 16'h0, 16'h1000, 4, 8'hA5, 0);
    chk("fill_last", mem[16'h1003], 8'hA5);

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33;
    run_xfer("copy", MODE_COPY, 16'h0, 16'h8000, 3, 8'h00, 0);
    chk("copy_last", mem[16'h8002], 8'h33);

    run_xfer("wrap", MODE_FILL, 16'h0, 16'hFFFE, 3, 8'h5A, 0);
    chk("wrap_zero", mem[16'h0000], 8'h5A);

    clear_mon();
    @(negedge clk);
    start = 1'b1;
    mode  = MODE_FILL;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done_next", done, 1);
    repeat (5) @(negedge clk);
    chk("len0_pulses", done_cnt, 1);
    chk("len0_busy", busy_seen, 0);
    chk("len0_valid", vld_seen, 0);

    clear_mon();
    kick(MODE_FILL, 16'h0, 16'h2000, 10, 8'h3C);
    begin
      int t;
      t = 0;
      while (!(wr_cnt >= 2 && mem_valid && mem_write) && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("rst_reached_wr", mem_valid && mem_write, 1);
    end
    reset = 1'b1;
    #1;
    chk("rst_async", {mem_valid, busy, count}, 0);
    ref_xfer(MODE_FILL, 16'h0, 16'h2000, wr_cnt, 8'h3C);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);
    mem_check("rst_mem");
    run_xfer("after_rst", MODE_FILL, 16'h0, 16'h2100, 5, 8'hC3, 0);

`ifdef DMA_TIMEOUT_EN
    never_rdy = 1;
    clear_mon();
    kick(MODE_COPY, 16'h0100, 16'h0200, 5, 8'h00);
    wait_done(200);
    repeat (2) @(negedge clk);
    chk("tmo_err", err_done, 1);
    chk("tmo_count", count, 0);
    chk("tmo_cycles", done_cyc - first_v, 8);
    chk("tmo_valid", mem_valid, 0);
    chk("tmo_err_held", err, 1);
    mem_check("tmo_mem");
    never_rdy = 0;
`endif

    for (int k = 0; k < 12; k++) begin
      logic        m;
      logic [15:0] s;
      logic [15:0] d;
      logic [7:0]  f;
      int          n;
      m = 1'($urandom_range(0, 1));
      n = $urandom_range(2, 40);
      s = 16'($urandom);
      d = (k % 4 == 3) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                       : 16'($urandom);
      if (k % 5 == 4) d = s + 16'($urandom_range(1, 4));
      f = 8'($urandom);
      stall_en = 1'($urandom_range(0, 1));
      run_xfer($sformatf("rnd%0d", k), m, s, d, n, f, 1);
    end
    stall_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
